axi_read_arbiter: RTL and testbench

Round-robin arbiter that shares one single-beat AXI-Lite-style read channel (AR + R) between `N_REQ` internal requesters. It sits between the requesters and the read-request front end. It allows exactly one outstanding read at a time and routes each response back to the requester that won the grant. A watchdog returns SLVERR when the downstream never answers, then drains the late response so the channel stays consistent.

---
 rtl/axi_read_arbiter_if.sv | 29 ++
 rtl/axi_read_arbiter.sv | 89 ++++++++
 tb/tb_axi_read_arbiter.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_read_arbiter_if.sv
// axi_read_arbiter_if: requester-side and downstream read-channel signals of the read arbiter.
interface axi_read_arbiter_if #(
   parameter int N_REQ  = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [N_REQ-1:0]        req_arvalid;
   logic [N_REQ*ADDR_W-1:0] req_araddr;
   logic [N_REQ-1:0]        req_arready;
   logic [N_REQ-1:0]        req_rvalid;
   logic [DATA_W-1:0]       req_rdata;
   logic [1:0]              req_rresp;
   logic [N_REQ-1:0]        req_rready;
   logic                    m_arvalid;
   logic [ADDR_W-1:0]       m_araddr;
   logic                    m_arready;
   logic                    m_rvalid;
   logic [DATA_W-1:0]       m_rdata;
   logic [1:0]              m_rresp;
   logic                    m_rready;
   modport master (
      input  req_arvalid, req_araddr, req_rready, m_arready, m_rvalid, m_rdata, m_rresp,
      output req_arready, req_rvalid, req_rdata, req_rresp, m_arvalid, m_araddr, m_rready
   );
   modport slave (
      output req_arvalid, req_araddr, req_rready, m_arready, m_rvalid, m_rdata, m_rresp,
      input  req_arready, req_rvalid, req_rdata, req_rresp, m_arvalid, m_araddr, m_rready
   );
endinterface

// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: round-robin sharing of one single-beat read channel, one outstanding read, with response watchdog.
module axi_read_arbiter #(
   parameter int N_REQ   = 4,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 256
) (
   input  logic                     clk,
   input  logic                     r_reset,
   axi_read_arbiter_if.master       bus,
   output logic [$clog2(N_REQ)-1:0] grant_id,
   output logic                     busy
);
   localparam int IW = $clog2(N_REQ);
   localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
   typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;
   state_t            state, state_nxt;
   logic [IW-1:0]     rr_ptr, win;
   logic [TW-1:0]     timer;
   logic [DATA_W-1:0] rdata;
   logic [1:0]        rresp;
   logic              stale, found, grant, tmo;
   int                j;
   // Scan downwards so the nearest requester at or after rr_ptr is the last to win.
   always_comb begin
      win = rr_ptr;
      found = 1'b0;
      j = 0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         j = (int'(rr_ptr) + k) % N_REQ;
         if (bus.req_arvalid[j]) begin
            win = IW'(j);
            found = 1'b1;
         end
      end
   end
   assign grant = state == IDLE && !stale && found;
   assign tmo = TIMEOUT != 0 && state == DATA && !bus.m_rvalid && timer == TW'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);
   assign bus.req_arready = grant ? N_REQ'(1) << win : '0;
   assign bus.req_rvalid = state == RESP ? N_REQ'(1) << grant_id : '0;
   assign bus.req_rdata = rdata;
   assign bus.req_rresp = rresp;
   assign bus.m_arvalid = state == ADDR;
   assign bus.m_rready = state == DATA || (state == IDLE && stale);
   assign busy = state != IDLE;
   always_ff @(posedge clk) begin
      if (!r_reset) state <= IDLE;
      else state <= state_nxt;
   end
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: state_nxt = grant ? ADDR : IDLE;
         ADDR: state_nxt = bus.m_arready ? DATA : ADDR;
         DATA: state_nxt = bus.m_rvalid || tmo ? RESP : DATA;
         RESP: state_nxt = bus.req_rready[grant_id] ? IDLE : RESP;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!r_reset) begin
         rr_ptr <= '0;
         grant_id <= '0;
         bus.m_araddr <= '0;
         timer <= '0;
         rdata <= '0;
         rresp <= '0;
         stale <= 1'b0;
      end else begin
         if (grant) begin
            bus.m_araddr <= bus.req_araddr[32'(win) * ADDR_W +: ADDR_W];
            grant_id <= win;
            rr_ptr <= win == IW'(N_REQ - 1) ? '0 : win + 1'b1;
         end
         if (state == ADDR && bus.m_arready) timer <= '0;
         if (state == DATA) timer <= timer + 1'b1;
         if (state == DATA && bus.m_rvalid) begin
            rdata <= bus.m_rdata;
            rresp <= bus.m_rresp;
         end
         // A timed-out read leaves one response owed downstream; stale drops it before new grants.
         if (tmo) begin
            rdata <= '0;
            rresp <= 2'b10;
            stale <= 1'b1;
         end
         if (state == IDLE && stale && bus.m_rvalid) stale <= 1'b0;
      end
   end
endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb_axi_read_arbiter: directed and randomized checks of the read arbiter against a transaction-level model.
module tb_axi_read_arbiter;
   localparam int N = 4, AW = 32, DW = 32, TO = 16;
   logic clk = 1'b0;
   logic r_reset = 1'b0;
   logic [1:0] grant_id;
   logic busy;
   int compared = 0, mismatched = 0;
   int rr = 0;
   logic stale_m = 1'b0;
   logic sticky = 1'b0;
   logic [N-1:0] pend = '0;
   logic [AW-1:0] addr [N];
   axi_read_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();
   axi_read_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .r_reset(r_reset), .bus(bus), .grant_id(grant_id), .busy(busy));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   function automatic int pick(input logic [N-1:0] p, input int ptr);
      for (int k = 0; k < N; k++) if (p[(ptr + k) % N]) return (ptr + k) % N;
      return -1;
   endfunction
   task automatic drive_req();
      bus.req_arvalid = pend;
      for (int i = 0; i < N; i++) bus.req_araddr[i*AW +: AW] = addr[i];
   endtask
   // One full transaction: grant now, then AR wait, R wait (or watchdog), then requester wait.
   task automatic run_txn(input int ar_dly, input int r_dly, input int rr_dly,
                          input logic [DW-1:0] data, input logic [1:0] resp, output int gid);
      int w;
      logic [AW-1:0] a;
      logic [DW-1:0] ed;
      logic [1:0] er;
      logic [N-1:0] oh;
      logic to;
      drive_req();
      w = pick(pend, rr);
      oh = N'(1) << w;
      @(negedge clk);
      chk("grant_ready", bus.req_arready, oh);
      chk("grant_busy", busy, 0);
      a = addr[w];
      rr = (w + 1) % N;
      if (!sticky) pend[w] = 1'b0;
      tick();
      drive_req();
      gid = int'(grant_id);
      for (int c = 0; c <= ar_dly; c++) begin
         bus.m_arready = c == ar_dly;
         @(negedge clk);
         chk("ar_valid", bus.m_arvalid, 1);
         chk("ar_addr", bus.m_araddr, a);
         chk("ar_rready", bus.m_rready, 0);
         chk("ar_gid", grant_id, w);
         chk("ar_noacc", bus.req_arready, 0);
         tick();
      end
      bus.m_arready = 1'b0;
      to = r_dly >= TO;
      for (int c = 0; c < (to ? TO : r_dly + 1); c++) begin
         bus.m_rvalid = !to && c == r_dly;
         bus.m_rdata = bus.m_rvalid ? data : DW'($urandom);
         bus.m_rresp = bus.m_rvalid ? resp : 2'($urandom);
         @(negedge clk);
         chk("data_rready", bus.m_rready, 1);
         chk("data_arvalid", bus.m_arvalid, 0);
         chk("data_rvalid", bus.req_rvalid, 0);
         chk("data_busy", busy, 1);
         tick();
      end
      bus.m_rvalid = 1'b0;
      ed = to ? '0 : data;
      er = to ? 2'b10 : resp;
      stale_m = to;
      for (int c = 0; c <= rr_dly; c++) begin
         bus.req_rready = c == rr_dly ? oh : N'($urandom) & ~oh;
         @(negedge clk);
         chk("resp_valid", bus.req_rvalid, oh);
         chk("resp_data", bus.req_rdata, ed);
         chk("resp_code", bus.req_rresp, er);
         chk("resp_rready", bus.m_rready, 0);
         chk("resp_noacc", bus.req_arready, 0);
         tick();
      end
      bus.req_rready = '0;
   endtask
   task automatic drain(input int wait_c);
      drive_req();
      for (int c = 0; c <= wait_c; c++) begin
         bus.m_rvalid = c == wait_c;
         bus.m_rdata = DW'($urandom);
         @(negedge clk);
         chk("drain_noacc", bus.req_arready, 0);
         chk("drain_rready", bus.m_rready, 1);
         chk("drain_busy", busy, 0);
         chk("drain_rvalid", bus.req_rvalid, 0);
         tick();
      end
      bus.m_rvalid = 1'b0;
      stale_m = 1'b0;
   endtask
   task automatic idle_check(input int n);
      drive_req();
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         chk("idle_busy", busy, 0);
         chk("idle_rvalid", bus.req_rvalid, 0);
         chk("idle_arvalid", bus.m_arvalid, 0);
         chk("idle_rready", bus.m_rready, stale_m);
         tick();
      end
   endtask
   initial begin
      int gid;
      int cnt [N];
      longint t0;
      logic [N-1:0] nw;
      bus.req_arvalid = '0;
      bus.req_araddr = '0;
      bus.req_rready = '0;
      bus.m_arready = 1'b0;
      bus.m_rvalid = 1'b0;
      bus.m_rdata = '0;
      bus.m_rresp = '0;
      for (int i = 0; i < N; i++) addr[i] = AW'($urandom);
      tick();
      tick();
      @(negedge clk);
      chk("rst_arready", bus.req_arready, 0);
      chk("rst_rvalid", bus.req_rvalid, 0);
      chk("rst_rdata", bus.req_rdata, 0);
      chk("rst_rresp", bus.req_rresp, 0);
      chk("rst_arvalid", bus.m_arvalid, 0);
      chk("rst_araddr", bus.m_araddr, 0);
      chk("rst_rready", bus.m_rready, 0);
      chk("rst_gid", grant_id, 0);
      chk("rst_busy", busy, 0);
      tick();
      r_reset = 1'b1;
      // Single request from requester 1.
      addr[1] = 32'h100;
      pend = 4'b0010;
      run_txn(0, 2, 0, 32'hDEADBEEF, 2'b00, gid);
      chk("single_gid", gid, 1);
      // Pointer now at 2: requester 3 outranks 0 and 1.
      pend = 4'b1011;
      run_txn(0, 0, 0, DW'($urandom), 2'b00, gid);
      chk("ptr_gid", gid, 3);
      pend = '0;
      idle_check(2);
      // Fairness with everyone requesting continuously; best-case 4-cycle round trip.
      sticky = 1'b1;
      pend = '1;
      for (int i = 0; i < N; i++) cnt[i] = 0;
      for (int k = 0; k < 8; k++) begin
         t0 = $time;
         run_txn(0, 0, 0, DW'($urandom), 2'($urandom), gid);
         chk("fair_order", gid, k % N);
         chk("fair_rtt", $time - t0, 40);
         cnt[gid % N]++;
      end
      for (int i = 0; i < N; i++) chk("fair_count", cnt[i], 2);
      sticky = 1'b0;
      pend = '0;
      // Backpressure on AR and on the requester side.
      addr[0] = AW'($urandom);
      pend = 4'b0001;
      run_txn(5, 1, 3, 32'h12345678, 2'b01, gid);
      idle_check(4);
      // Watchdog timeout, then a pending request waits for the late response to be dropped.
      pend = 4'b0010;
      run_txn(0, TO + 4, 1, 32'hCAFEF00D, 2'b00, gid);
      chk("to_stale_model", stale_m, 1);
      addr[3] = AW'($urandom);
      pend = 4'b1000;
      drain(5);
      run_txn(1, 2, 0, 32'hA5A5A5A5, 2'b00, gid);
      chk("after_drain_gid", gid, 3);
      // Response arrives in the timeout cycle: real data, no stale.
      pend = 4'b0001;
      run_txn(0, TO - 1, 0, 32'h0BADCAFE, 2'b01, gid);
      pend = 4'b0100;
      run_txn(0, 0, 0, DW'($urandom), 2'b00, gid);
      chk("race_next_gid", gid, 2);
      // Reset while in DATA.
      pend = 4'b0100;
      drive_req();
      tick();
      pend = '0;
      drive_req();
      bus.m_arready = 1'b1;
      tick();
      bus.m_arready = 1'b0;
      tick();
      @(negedge clk);
      chk("mid_in_data", bus.m_rready, 1);
      r_reset = 1'b0;
      tick();
      r_reset = 1'b1;
      @(negedge clk);
      chk("mrst_arready", bus.req_arready, 0);
      chk("mrst_rvalid", bus.req_rvalid, 0);
      chk("mrst_rdata", bus.req_rdata, 0);
      chk("mrst_rresp", bus.req_rresp, 0);
      chk("mrst_arvalid", bus.m_arvalid, 0);
      chk("mrst_araddr", bus.m_araddr, 0);
      chk("mrst_rready", bus.m_rready, 0);
      chk("mrst_gid", grant_id, 0);
      chk("mrst_busy", busy, 0);
      tick();
      rr = 0;
      stale_m = 1'b0;
      pend = '1;
      run_txn(0, 1, 0, DW'($urandom), 2'b00, gid);
      chk("mrst_first_gid", gid, 0);
      // Randomized traffic, including occasional timeouts.
      for (int k = 0; k < 30; k++) begin
         nw = N'($urandom_range(1, (1 << N) - 1)) & ~pend;
         for (int i = 0; i < N; i++) if (nw[i]) addr[i] = AW'($urandom);
         pend = pend | nw;
         run_txn($urandom_range(0, 4), $urandom_range(0, TO + 2), $urandom_range(0, 3),
                 DW'($urandom), 2'($urandom), gid);
         if (stale_m) drain($urandom_range(0, 3));
      end
      pend = '0;
      idle_check(3);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
